// File: rtl/ddr_chart_player.sv
// ddr_chart_player
// Plays a step chart stored in a synchronous ROM against the sixteenth-note
// tick. Each ROM byte is {mask[3:0], duration[3:0]}. The block issues every
// non-zero mask to the arrow spawner over valid/ready, then waits out the
// duration in ticks before fetching the next entry.
//
// Build option: define CHART_LOOP_EN to make an END marker or the last
// address wrap back to address 0 instead of stopping in DONE.

module ddr_chart_player #(
  parameter int ADDR_W = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sixteenth_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [3:0]        arrows_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              playing_o,
  output logic              done_o,
  output logic [STEP_W-1:0] step_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_COUNT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [3:0]         mask_q, mask_d;
  logic [3:0]         remaining_q, remaining_d;
  logic               pend_q, pend_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               playing_q, playing_d;
  logic               done_q, done_d;

  // Intermediate decode signals used by the next-state logic.
  logic               advance_s;
  logic               end_s;
  logic               pend_eff_s;
  logic [3:0]         dur_s;
  logic [3:0]         rem_dec_s;

  // Next-state, datapath and flag logic for the chart player.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    pend_d      = pend_q;
    step_d      = step_q;
    advance_s   = 1'b0;
    end_s       = 1'b0;
    dur_s       = rom_data_i[3:0];
    pend_eff_s  = pend_q | sixteenth_i;
    rem_dec_s   = remaining_q;

    if (stop_i) begin
      // Abort: step holds, pending tick is discarded.
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else begin
      // Every playing state counts ticks into the step counter.
      if (sixteenth_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
        step_d = step_q + STEP_ONE;
      end else begin
        step_d = step_q;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d = S_FETCH;
            addr_d  = {ADDR_W{1'b0}};
            step_d  = {STEP_W{1'b0}};
            pend_d  = 1'b0;
          end else begin
            state_d = state_q;
          end
        end

        S_FETCH: begin
          state_d = S_WAIT;
          if (sixteenth_i) begin
            pend_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end

        S_WAIT: begin
          // A tick arriving in the latch cycle itself is folded in as well.
          pend_d      = 1'b0;
          mask_d      = rom_data_i[7:4];
          remaining_d = dur_s - {3'b000, pend_eff_s};
          if (dur_s == 4'd0) begin
            end_s       = 1'b1;
            mask_d      = 4'd0;
            remaining_d = 4'd0;
          end else if (rom_data_i[7:4] == 4'd0) begin
            // Rest: no handshake; a fully pre-consumed rest advances at once.
            if ((dur_s - {3'b000, pend_eff_s}) == 4'd0) begin
              advance_s = 1'b1;
            end else begin
              state_d = S_COUNT;
            end
          end else begin
            state_d = S_EMIT;
          end
        end

        S_EMIT: begin
          // Ticks keep draining the duration while the spawner stalls.
          if (sixteenth_i && (remaining_q != 4'd0)) begin
            rem_dec_s = remaining_q - 4'd1;
          end else begin
            rem_dec_s = remaining_q;
          end
          remaining_d = rem_dec_s;
          if (ready_i) begin
            if (rem_dec_s == 4'd0) begin
              advance_s = 1'b1;
            end else begin
              state_d = S_COUNT;
            end
          end else begin
            state_d = S_EMIT;
          end
        end

        S_COUNT: begin
          if (sixteenth_i) begin
            if (remaining_q <= 4'd1) begin
              remaining_d = 4'd0;
              advance_s   = 1'b1;
            end else begin
              remaining_d = remaining_q - 4'd1;
            end
          end else begin
            remaining_d = remaining_q;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // END marker or last address: stop, or wrap when looping.
      if (end_s || (advance_s && (addr_q == ADDR_LAST))) begin
`ifdef CHART_LOOP_EN
        state_d = S_FETCH;
        addr_d  = {ADDR_W{1'b0}};
`else
        state_d = S_DONE;
`endif
      end else if (advance_s) begin
        state_d = S_FETCH;
        addr_d  = addr_q + ADDR_ONE;
      end else begin
        addr_d = addr_d;
      end
    end

    playing_d = (state_d == S_FETCH) || (state_d == S_WAIT) ||
                (state_d == S_EMIT)  || (state_d == S_COUNT);
    done_d    = (state_d == S_DONE);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      mask_q      <= 4'd0;
      remaining_q <= 4'd0;
      pend_q      <= 1'b0;
      step_q      <= {STEP_W{1'b0}};
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      pend_q      <= pend_d;
      step_q      <= step_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
    end
  end

  // valid/arrows decode straight from the state and mask flops.
  assign valid_o    = (state_q == S_EMIT);
  assign arrows_o   = valid_o ? mask_q : 4'd0;
  assign rom_addr_o = addr_q;
  assign playing_o  = playing_q;
  assign done_o     = done_q;
  assign step_o     = step_q;

endmodule

// File: doc/ddr_chart_player.md
# ddr_chart_player

Reads a step chart from a synchronous ROM and plays it against the sixteenth-note tick from the beat timing generator. Each chart entry gives an arrow mask and a duration in sixteenth notes. The block issues each arrow mask to the arrow spawner over a valid/ready handshake, then waits out the duration before fetching the next entry. It sits between the timing generator and the arrow/scroll logic, and is the consumer of the note-timing pulses.

## Interface
Parameters:
- ADDR_W, 8 — chart ROM address width; chart holds up to 2^ADDR_W entries
- STEP_W, 16 — width of the elapsed-sixteenths counter

Ports:
- clk_i  input  1  single clock for the whole block
- rst_ni  input  1  reset, asynchronous and active-low
- sixteenth_i  input  1  one-cycle sixteenth-note tick from the timing generator
- start_i  input  1  start playback from address 0; ignored unless in IDLE or DONE
- stop_i  input  1  abort to IDLE; takes priority over every other input
- rom_addr_o  output  ADDR_W  chart ROM read address
- rom_data_i  input  8  ROM data, one cycle after the address; bits [7:4] = mask {L,D,U,R}, bits [3:0] = duration
- arrows_o  output  4  arrow mask to the spawner
- valid_o  output  1  arrows_o valid
- ready_i  input  1  spawner accepts
- playing_o  output  1  high in FETCH, WAIT, EMIT, COUNT
- done_o  output  1  high in DONE
- step_o  output  STEP_W  sixteenth ticks counted since the last start

## Operation
- Entry encoding:
  - A duration of 0 is the END marker; its mask is ignored.
  - A mask of 0 with a nonzero duration is a rest, and no handshake occurs.
- States and transitions:
  - IDLE: start_i → FETCH, with addr=0 and step_o=0.
  - FETCH: drive rom_addr_o=addr → WAIT.
  - WAIT: latch rom_data_i at the end of the cycle.
    - END marker → DONE.
    - Rest → COUNT.
    - Otherwise → EMIT.
    - remaining is loaded with the duration, minus 1 if pend is set; pend then clears.
  - EMIT: valid_o=1 and arrows_o=mask, both held stable until ready_i.
    - On handshake: if remaining==0 → ADVANCE, else → COUNT.
  - COUNT: on sixteenth_i, remaining decrements; when it reaches 0 → ADVANCE.
  - ADVANCE (combinational step, not a state):
    - If addr == 2^ADDR_W−1 → DONE.
    - Otherwise addr+1 → FETCH.
  - DONE: start_i → FETCH with addr=0 and step_o=0.
- Tick handling:
  - A sixteenth_i seen in FETCH or WAIT sets the 1-bit pend flag, so no tick is lost. A second tick in the same window is dropped; this cannot occur with real tick spacing.
  - sixteenth_i in EMIT decrements remaining, saturating at 0.
  - In every state except IDLE and DONE, sixteenth_i increments step_o, which wraps modulo 2^STEP_W.
- Priority and other rules:
  - stop_i in any state → IDLE next cycle: valid_o drops, pend clears, step_o holds its value.
  - start_i while playing is ignored.
  - arrows_o is 0 whenever valid_o is 0.

## Timing
- Reset values:
  - Outputs: rom_addr_o=0, arrows_o=0, valid_o=0, playing_o=0, done_o=0, step_o=0.
  - Internal: state IDLE, pend=0.
- start_i sampled high at cycle N:
  - FETCH at N+1.
  - WAIT at N+2 (rom_data_i valid, latched at the end of N+2).
  - valid_o high at N+3.
- Handshake:
  - The transfer occurs on the cycle where valid_o && ready_i.
  - valid_o deasserts the following cycle.
  - If ready_i is already high when valid_o rises, the transfer takes exactly one cycle.
- Entry-to-entry spacing:
  - A duration-d entry ends on its d-th tick after the latch.
  - The next entry's valid_o rises 3 cycles after that tick: ADVANCE → FETCH → WAIT → EMIT.
- Backpressure: if the duration expires during EMIT, the block advances on the handshake cycle. Lateness is absorbed there, and later entries keep tick alignment.
- All outputs are registered except arrows_o and valid_o, which decode directly from the state flop and the mask flop.

## Configuration
- CHART_LOOP_EN
  - Defined: an END marker, or completion of the last address, returns to FETCH with addr=0 instead of DONE; done_o never asserts. step_o continues counting without reset.
  - Undefined: behaviour is as described above; the block stops in DONE.

## Test plan
- Reset while in EMIT with valid_o=1 (rst_ni low mid-cycle) → all outputs 0 immediately, without waiting for a clock edge.
- ROM {0x12, 0x01, 0x00}, ready_i=1, tick every 20 cycles, start at cycle 0:
  - arrows_o=0x1 with valid at cycle 3.
  - arrows_o=0x0 (rest, no valid) follows.
  - done_o rises after the END fetch.
  - step_o=3.
- ROM {0x81, 0x41, 0x00}, ready_i held 0 across 3 ticks:
  - valid_o and arrows_o=0x8 stay stable.
  - Releasing ready_i → the next entry's valid_o with arrows_o=0x4 rises 3 cycles after the handshake.
- Tick coincident with the FETCH cycle of entry {0xF2}: pend is taken, and the entry finishes after exactly 1 further tick.
- stop_i asserted in COUNT together with sixteenth_i → IDLE next cycle, step_o not incremented. start_i in IDLE → rom_addr_o=0.
- ADDR_W=2, no END marker, all entries 0x11:
  - Without CHART_LOOP_EN, DONE after address 3.
  - With CHART_LOOP_EN, rom_addr_o wraps 3→0 and valid_o recurs every tick + 3 cycles.
